// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Opcode/funct/ALUOp constants and per-stage control words
//               shared by the pipelined MIPS control path.
// Revision    : 1.0
// ============================================================================
package ctrl_pkg;

    localparam int c_REG_W = 5;

    localparam logic [5:0] c_OP_RTYPE  = 6'b000000;
    localparam logic [5:0] c_OP_REGIMM = 6'b000001;
    localparam logic [5:0] c_OP_J      = 6'b000010;
    localparam logic [5:0] c_OP_JAL    = 6'b000011;
    localparam logic [5:0] c_OP_BEQ    = 6'b000100;
    localparam logic [5:0] c_OP_BNE    = 6'b000101;
    localparam logic [5:0] c_OP_BLEZ   = 6'b000110;
    localparam logic [5:0] c_OP_BGTZ   = 6'b000111;
    localparam logic [5:0] c_OP_ADDI   = 6'b001000;
    localparam logic [5:0] c_OP_SLTI   = 6'b001010;
    localparam logic [5:0] c_OP_ANDI   = 6'b001100;
    localparam logic [5:0] c_OP_ORI    = 6'b001101;
    localparam logic [5:0] c_OP_XORI   = 6'b001110;
    localparam logic [5:0] c_OP_MUL    = 6'b011100;
    localparam logic [5:0] c_OP_LB     = 6'b100000;
    localparam logic [5:0] c_OP_LH     = 6'b100001;
    localparam logic [5:0] c_OP_LW     = 6'b100011;
    localparam logic [5:0] c_OP_SB     = 6'b101000;
    localparam logic [5:0] c_OP_SH     = 6'b101001;
    localparam logic [5:0] c_OP_SW     = 6'b101011;

    localparam logic [5:0] c_FN_SLL = 6'b000000;
    localparam logic [5:0] c_FN_SRL = 6'b000010;
    localparam logic [5:0] c_FN_JR  = 6'b001000;
    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_XOR = 6'b100110;
    localparam logic [5:0] c_FN_NOR = 6'b100111;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    localparam logic [5:0] c_ALU_ADD  = 6'b100000;
    localparam logic [5:0] c_ALU_AND  = 6'b100100;
    localparam logic [5:0] c_ALU_OR   = 6'b100101;
    localparam logic [5:0] c_ALU_XOR  = 6'b100110;
    localparam logic [5:0] c_ALU_SLT  = 6'b101010;
    localparam logic [5:0] c_ALU_JUMP = 6'b110000;
    localparam logic [5:0] c_ALU_MUL  = 6'b111000;
    localparam logic [5:0] c_ALU_BEQ  = 6'b100010;
    localparam logic [5:0] c_ALU_BNE  = 6'b001001;
    localparam logic [5:0] c_ALU_BGTZ = 6'b001111;
    localparam logic [5:0] c_ALU_BLEZ = 6'b001010;
    localparam logic [5:0] c_ALU_BLTZ = 6'b001011;
    localparam logic [5:0] c_ALU_BGEZ = 6'b001000;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_BYTE = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic [5:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       jr;
        logic       jump_target;
        logic       jal;
        logic       illegal;
    } ex_ctrl_t;

    typedef struct packed {
        logic      mem_read;
        logic      mem_write;
        mem_size_e load;
        mem_size_e store;
    } mem_ctrl_t;

    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic [c_REG_W-1:0] write_reg;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_word_t;

    typedef struct packed {
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } mem_stage_t;

    localparam ctrl_word_t c_BUBBLE     = '0;
    localparam mem_stage_t c_MEM_BUBBLE = '0;
    localparam wb_ctrl_t   c_WB_BUBBLE  = '0;

    function automatic logic [5:0] imm_alu_op(input logic [5:0] op);
        logic [5:0] r;
        case (op)
            c_OP_ANDI: r = c_ALU_AND;
            c_OP_ORI:  r = c_ALU_OR;
            c_OP_XORI: r = c_ALU_XOR;
            c_OP_SLTI: r = c_ALU_SLT;
            default:   r = c_ALU_ADD;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe_if
// Description : ID-stage instruction inputs and staged control outputs.
// Revision    : 1.0
// ============================================================================
interface ctrl_pipe_if #(
    parameter int REG_ADDR_W = 5
);
    logic [31:0]           Instruction;
    logic                  InstrValid;
    logic                  BranchTaken;
    logic                  Stall;
    logic [5:0]            ALUOp_EX;
    logic                  ALUSrc_EX;
    logic                  Branch_EX;
    logic                  jr_EX;
    logic                  jump_target_EX;
    logic                  jal_EX;
    logic                  Illegal_EX;
    logic                  MemRead_MEM;
    logic                  MemWrite_MEM;
    logic [1:0]            load_MEM;
    logic [1:0]            store_MEM;
    logic                  RegWrite_WB;
    logic                  MemToReg_WB;
    logic [REG_ADDR_W-1:0] WriteReg_WB;

    modport master (
        output Instruction, InstrValid, BranchTaken,
        input  Stall, ALUOp_EX, ALUSrc_EX, Branch_EX, jr_EX, jump_target_EX,
               jal_EX, Illegal_EX, MemRead_MEM, MemWrite_MEM, load_MEM,
               store_MEM, RegWrite_WB, MemToReg_WB, WriteReg_WB
    );

    modport slave (
        input  Instruction, InstrValid, BranchTaken,
        output Stall, ALUOp_EX, ALUSrc_EX, Branch_EX, jr_EX, jump_target_EX,
               jal_EX, Illegal_EX, MemRead_MEM, MemWrite_MEM, load_MEM,
               store_MEM, RegWrite_WB, MemToReg_WB, WriteReg_WB
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational MIPS instruction to control-word decoder.
// Revision    : 1.0
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int RA_REG = 31
) (
    input  wire logic         i_valid,
    input  wire logic [5:0]   i_opcode,
    input  wire logic [4:0]   i_rt,
    input  wire logic [4:0]   i_rd,
    input  wire logic [5:0]   i_funct,
    output      ctrl_word_t   o_ctrl
);

    always_comb begin
        o_ctrl = c_BUBBLE;
        if (i_valid) begin
            case (i_opcode)
                c_OP_RTYPE: begin
                    case (i_funct)
                        c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_NOR,
                        c_FN_XOR, c_FN_SLT, c_FN_SLL, c_FN_SRL: begin
                            o_ctrl.ex.alu_op  = i_funct;
                            o_ctrl.ex.alu_src = (i_funct == c_FN_SLL) || (i_funct == c_FN_SRL);
                            o_ctrl.wb         = '{reg_write: 1'b1, mem_to_reg: 1'b1, write_reg: i_rd};
                        end
                        c_FN_JR: begin
                            o_ctrl.ex.alu_op = c_ALU_JUMP;
                            o_ctrl.ex.branch = 1'b1;
                            o_ctrl.ex.jr     = 1'b1;
                        end
                        default: o_ctrl.ex.illegal = 1'b1;
                    endcase
                end
                c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_XORI, c_OP_SLTI: begin
                    o_ctrl.ex.alu_op  = imm_alu_op(i_opcode);
                    o_ctrl.ex.alu_src = 1'b1;
                    o_ctrl.wb         = '{reg_write: 1'b1, mem_to_reg: 1'b1, write_reg: i_rt};
                end
                c_OP_MUL: begin
                    o_ctrl.ex.alu_op = c_ALU_MUL;
                    o_ctrl.wb        = '{reg_write: 1'b1, mem_to_reg: 1'b1, write_reg: i_rd};
                end
                c_OP_BEQ:  begin o_ctrl.ex.alu_op = c_ALU_BEQ;  o_ctrl.ex.branch = 1'b1; end
                c_OP_BNE:  begin o_ctrl.ex.alu_op = c_ALU_BNE;  o_ctrl.ex.branch = 1'b1; end
                c_OP_BGTZ: begin o_ctrl.ex.alu_op = c_ALU_BGTZ; o_ctrl.ex.branch = 1'b1; end
                c_OP_BLEZ: begin o_ctrl.ex.alu_op = c_ALU_BLEZ; o_ctrl.ex.branch = 1'b1; end
                c_OP_REGIMM: begin
                    // rt selects the comparison; any other rt code is undefined here
                    case (i_rt)
                        5'd0: begin o_ctrl.ex.alu_op = c_ALU_BLTZ; o_ctrl.ex.branch = 1'b1; end
                        5'd1: begin o_ctrl.ex.alu_op = c_ALU_BGEZ; o_ctrl.ex.branch = 1'b1; end
                        default: o_ctrl.ex.illegal = 1'b1;
                    endcase
                end
                c_OP_J, c_OP_JAL: begin
                    o_ctrl.ex.alu_op      = c_ALU_JUMP;
                    o_ctrl.ex.branch      = 1'b1;
                    o_ctrl.ex.jump_target = 1'b1;
                    if (i_opcode == c_OP_JAL) begin
                        o_ctrl.ex.jal = 1'b1;
                        o_ctrl.wb     = '{reg_write: 1'b1, mem_to_reg: 1'b1,
                                          write_reg: c_REG_W'(RA_REG)};
                    end
                end
                c_OP_LW, c_OP_LH, c_OP_LB: begin
                    o_ctrl.ex.alu_op    = c_ALU_ADD;
                    o_ctrl.ex.alu_src   = 1'b1;
                    o_ctrl.mem.mem_read = 1'b1;
                    o_ctrl.mem.load     = (i_opcode == c_OP_LW) ? SIZE_WORD :
                                          (i_opcode == c_OP_LH) ? SIZE_HALF : SIZE_BYTE;
                    o_ctrl.wb           = '{reg_write: 1'b1, mem_to_reg: 1'b0, write_reg: i_rt};
                end
                c_OP_SW, c_OP_SH, c_OP_SB: begin
                    o_ctrl.ex.alu_op     = c_ALU_ADD;
                    o_ctrl.ex.alu_src    = 1'b1;
                    o_ctrl.mem.mem_write = 1'b1;
                    o_ctrl.mem.store     = (i_opcode == c_OP_SW) ? SIZE_WORD :
                                           (i_opcode == c_OP_SH) ? SIZE_HALF : SIZE_BYTE;
                end
                default: o_ctrl.ex.illegal = 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe
// Description : Staged control path: ID decode, ID/EX, EX/MEM, MEM/WB slices,
//               load-use stall and taken-branch squash.
// Revision    : 1.0
// ============================================================================
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int RA_REG     = 31,
    parameter int STALL_EN   = 1
) (
    input wire logic  Clk,
    input wire logic  Reset,
    ctrl_pipe_if.slave bus
);

    logic [5:0] w_opcode;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_reads_rt;
    logic       w_hazard;
    logic       w_unused_shamt;

    ctrl_word_t w_dec;
    ctrl_word_t w_ex_d;
    ctrl_word_t r_ex_q;
    mem_stage_t w_mem_d;
    mem_stage_t r_mem_q;
    wb_ctrl_t   w_wb_d;
    wb_ctrl_t   r_wb_q;

    assign w_opcode       = bus.Instruction[31:26];
    assign w_rs           = bus.Instruction[25:21];
    assign w_rt           = bus.Instruction[20:16];
    assign w_unused_shamt = ^bus.Instruction[10:6];

    ctrl_decode #(
        .RA_REG (RA_REG)
    ) u_decode (
        .i_valid  (bus.InstrValid),
        .i_opcode (w_opcode),
        .i_rt     (w_rt),
        .i_rd     (bus.Instruction[15:11]),
        .i_funct  (bus.Instruction[5:0]),
        .o_ctrl   (w_dec)
    );

    always_comb begin
        w_reads_rt = (w_opcode == c_OP_RTYPE) || (w_opcode == c_OP_BEQ) ||
                     (w_opcode == c_OP_BNE)   || (w_opcode == c_OP_SW)  ||
                     (w_opcode == c_OP_SH)    || (w_opcode == c_OP_SB);
        w_hazard   = (STALL_EN != 0) && bus.InstrValid && r_ex_q.mem.mem_read &&
                     (r_ex_q.wb.write_reg != '0) &&
                     ((r_ex_q.wb.write_reg == w_rs) ||
                      (w_reads_rt && (r_ex_q.wb.write_reg == w_rt)));
        // A squash overrides the hazard: the dependent instruction is discarded anyway
        bus.Stall  = w_hazard && !bus.BranchTaken;
        w_ex_d     = (bus.BranchTaken || w_hazard) ? c_BUBBLE : w_dec;
        w_mem_d    = '{mem: r_ex_q.mem, wb: r_ex_q.wb};
        w_wb_d     = r_mem_q.wb;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ex_q  <= c_BUBBLE;
            r_mem_q <= c_MEM_BUBBLE;
            r_wb_q  <= c_WB_BUBBLE;
        end else begin
            r_ex_q  <= w_ex_d;
            r_mem_q <= w_mem_d;
            r_wb_q  <= w_wb_d;
        end
    end

    assign bus.ALUOp_EX       = r_ex_q.ex.alu_op;
    assign bus.ALUSrc_EX      = r_ex_q.ex.alu_src;
    assign bus.Branch_EX      = r_ex_q.ex.branch;
    assign bus.jr_EX          = r_ex_q.ex.jr;
    assign bus.jump_target_EX = r_ex_q.ex.jump_target;
    assign bus.jal_EX         = r_ex_q.ex.jal;
    assign bus.Illegal_EX     = r_ex_q.ex.illegal;
    assign bus.MemRead_MEM    = r_mem_q.mem.mem_read;
    assign bus.MemWrite_MEM   = r_mem_q.mem.mem_write;
    assign bus.load_MEM       = r_mem_q.mem.load;
    assign bus.store_MEM      = r_mem_q.mem.store;
    assign bus.RegWrite_WB    = r_wb_q.reg_write;
    assign bus.MemToReg_WB    = r_wb_q.mem_to_reg;
    assign bus.WriteReg_WB    = REG_ADDR_W'(r_wb_q.write_reg);

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_pipe
// Description : Directed self-checking bench for ctrl_pipe.
// Revision    : 1.0
// ============================================================================
module tb_ctrl_pipe;

    localparam logic [31:0] c_ADD1   = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] c_LW2    = 32'h8C22_0000; // lw  $2,0($1)
    localparam logic [31:0] c_ADDDEP = 32'h0044_1820; // add $3,$2,$4
    localparam logic [31:0] c_LW0    = 32'h8C20_0000; // lw  $0,0($1)
    localparam logic [31:0] c_ADDR0  = 32'h0004_1820; // add $3,$0,$4
    localparam logic [31:0] c_JAL    = 32'h0C00_0100; // jal 0x100
    localparam logic [31:0] c_SB     = 32'hA025_0000; // sb  $5,0($1)
    localparam logic [31:0] c_ILL    = 32'hFC00_0000; // opcode 111111
    localparam logic [31:0] c_BGEZ   = 32'h0421_0000; // bgez $1
    localparam logic [31:0] c_SRL    = 32'h0002_1902; // srl $3,$2,4

    // {ALUOp, ALUSrc, Branch, jr, jump_target, jal, Illegal}
    localparam logic [11:0] c_EX_ADD  = {6'b100000, 6'b000000};
    localparam logic [11:0] c_EX_LDST = {6'b100000, 6'b100000};
    localparam logic [11:0] c_EX_JAL  = {6'b110000, 6'b010110};
    localparam logic [11:0] c_EX_ILL  = {6'b000000, 6'b000001};
    localparam logic [11:0] c_EX_BGEZ = {6'b001000, 6'b010000};
    localparam logic [11:0] c_EX_SRL  = {6'b000010, 6'b100000};

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_errors;

    ctrl_pipe_if #(.REG_ADDR_W(5)) bus ();

    ctrl_pipe #(
        .REG_ADDR_W (5),
        .RA_REG     (31),
        .STALL_EN   (1)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ex_vec();
        return {bus.ALUOp_EX, bus.ALUSrc_EX, bus.Branch_EX, bus.jr_EX,
                bus.jump_target_EX, bus.jal_EX, bus.Illegal_EX};
    endfunction

    function automatic logic [5:0] mem_vec();
        return {bus.MemRead_MEM, bus.MemWrite_MEM, bus.load_MEM, bus.store_MEM};
    endfunction

    function automatic logic [6:0] wb_vec();
        return {bus.RegWrite_WB, bus.MemToReg_WB, bus.WriteReg_WB};
    endfunction

    // Advance one edge, then present the next ID-stage inputs and let them settle
    task automatic cyc(input logic [31:0] instr, input logic valid, input logic br);
        @(posedge Clk);
        #1;
        bus.Instruction = instr;
        bus.InstrValid  = valid;
        bus.BranchTaken = br;
        #1;
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        Reset           = 1'b1;
        bus.Instruction = c_LW2;
        bus.InstrValid  = 1'b1;
        bus.BranchTaken = 1'b0;

        repeat (2) @(posedge Clk);
        #1;
        check("rst_ex",    32'(ex_vec()),  32'h0);
        check("rst_mem",   32'(mem_vec()), 32'h0);
        check("rst_wb",    32'(wb_vec()),  32'h0);
        check("rst_stall", 32'(bus.Stall), 32'h0);
        Reset = 1'b0;

        // plain R-type through all three stages
        bus.Instruction = c_ADD1;
        #1;
        cyc(32'h0, 1'b0, 1'b0);
        check("add_ex", 32'(ex_vec()), 32'(c_EX_ADD));
        cyc(32'h0, 1'b0, 1'b0);
        check("add_mem", 32'(mem_vec()), 32'h0);
        cyc(32'h0, 1'b0, 1'b0);
        check("add_wb", 32'(wb_vec()), 32'({1'b1, 1'b1, 5'd3}));

        // load-use: one stall, bubble, then add one cycle late
        cyc(c_LW2, 1'b1, 1'b0);
        check("lu_nostall0", 32'(bus.Stall), 32'h0);
        cyc(c_ADDDEP, 1'b1, 1'b0);
        check("lu_stall", 32'(bus.Stall), 32'h1);
        check("lu_ex_lw", 32'(ex_vec()), 32'(c_EX_LDST));
        cyc(c_ADDDEP, 1'b1, 1'b0);
        check("lu_stall_once", 32'(bus.Stall), 32'h0);
        check("lu_bubble", 32'(ex_vec()), 32'h0);
        check("lu_mem_lw", 32'(mem_vec()), 32'({1'b1, 1'b0, 2'd0, 2'd0}));
        cyc(32'h0, 1'b0, 1'b0);
        check("lu_ex_add", 32'(ex_vec()), 32'(c_EX_ADD));
        check("lu_wb_lw", 32'(wb_vec()), 32'({1'b1, 1'b0, 5'd2}));

        // load to $0 never stalls
        cyc(c_LW0, 1'b1, 1'b0);
        cyc(c_ADDR0, 1'b1, 1'b0);
        check("r0_nostall", 32'(bus.Stall), 32'h0);
        cyc(32'h0, 1'b0, 1'b0);
        check("r0_ex_add", 32'(ex_vec()), 32'(c_EX_ADD));

        // flush wins over hazard
        cyc(c_LW2, 1'b1, 1'b0);
        cyc(c_ADDDEP, 1'b1, 1'b1);
        check("fl_nostall", 32'(bus.Stall), 32'h0);
        cyc(32'h0, 1'b0, 1'b0);
        check("fl_bubble", 32'(ex_vec()), 32'h0);

        // jal writes the link register
        cyc(c_JAL, 1'b1, 1'b0);
        cyc(32'h0, 1'b0, 1'b0);
        check("jal_ex", 32'(ex_vec()), 32'(c_EX_JAL));
        cyc(32'h0, 1'b0, 1'b0);
        cyc(32'h0, 1'b0, 1'b0);
        check("jal_wb", 32'(wb_vec()), 32'({1'b1, 1'b1, 5'd31}));

        // byte store followed by an illegal opcode
        cyc(c_SB, 1'b1, 1'b0);
        cyc(c_ILL, 1'b1, 1'b0);
        check("sb_ex", 32'(ex_vec()), 32'(c_EX_LDST));
        cyc(32'h0, 1'b0, 1'b0);
        check("ill_ex", 32'(ex_vec()), 32'(c_EX_ILL));
        check("sb_mem", 32'(mem_vec()), 32'({1'b0, 1'b1, 2'd0, 2'd2}));
        cyc(32'h0, 1'b0, 1'b0);
        check("ill_mem", 32'(mem_vec()), 32'h0);
        check("sb_wb", 32'(wb_vec()), 32'h0);
        cyc(32'h0, 1'b0, 1'b0);
        check("ill_wb", 32'(wb_vec()), 32'h0);

        // REGIMM rt=1 and a shift
        cyc(c_BGEZ, 1'b1, 1'b0);
        cyc(c_SRL, 1'b1, 1'b0);
        check("bgez_ex", 32'(ex_vec()), 32'(c_EX_BGEZ));
        cyc(32'h0, 1'b0, 1'b0);
        check("srl_ex", 32'(ex_vec()), 32'(c_EX_SRL));

        // reset mid-stall
        cyc(c_LW2, 1'b1, 1'b0);
        cyc(c_ADDDEP, 1'b1, 1'b0);
        check("rs_stall", 32'(bus.Stall), 32'h1);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("rs_ex",    32'(ex_vec()),  32'h0);
        check("rs_mem",   32'(mem_vec()), 32'h0);
        check("rs_wb",    32'(wb_vec()),  32'h0);
        check("rs_stall0", 32'(bus.Stall), 32'h0);
        Reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
